amp_trig_sched: RTL and testbench
=================================

Name: amp_trig_sched

Overview:
- Multi-channel amplifier trigger scheduler.
- Synchronises an external trigger, builds a coarse time base from clock blocks, and fires a one-cycle pulse on each enabled channel at a programmed block delay.
- Provides double-buffered per-channel configuration. Writes take effect only between triggers, so a pulse train is never corrupted mid-sequence.
- Sits between the trigger input pin and the amplifier trigger outputs; configured by the control-register decoder.

Parameters:
- NCH, 4, number of trigger output channels (1..8).
- BLK_SIZE, 20, block prescale; one delay unit = BLK_SIZE+1 clocks.
- DLY_W, 7, delay field width in blocks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- trigger_in  in  1  asynchronous external trigger, level-high.
- global_en  in  1  accepts triggers when high.
- cfg_wr  in  1  one-cycle config write strobe.
- cfg_ch  in  3  channel index for write; writes with cfg_ch>=NCH are ignored but still acked.
- cfg_en  in  1  channel enable value.
- cfg_delay  in  DLY_W  channel delay value, in blocks.
- cfg_ack  out  1  one-cycle pulse, the cycle after cfg_wr.
- cfg_pending  out  1  shadow config not yet applied.
- miss_clr  in  1  clears miss flags.
- amp_trig  out  NCH  per-channel one-cycle trigger pulses.
- busy  out  1  state != IDLE.
- trig_count  out  16  accepted-trigger counter, wraps at 0xFFFF->0.
- miss  out  NCH  sticky: enabled channel did not fire before trigger fell.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Shadow and active config cleared (all channels disabled, delay 0).
  - Sync flops, edge register and armed flag all 0.
- Sync and edge detect:
  - trigger_in passes through 2 flops to give trig_s; trig_d is trig_s registered.
  - Edge = trig_s & ~trig_d & armed.
  - armed sets the first cycle trig_s==0 after reset, so a trigger held high through reset release is not an edge.
- Config handshake:
  - cfg_wr writes the shadow entry for cfg_ch, sets cfg_pending, and pulses cfg_ack on the next cycle.
  - In IDLE, when pending and no edge is present this cycle: shadow is copied to active and cfg_pending clears.
  - A write on the same cycle as an accepted edge is not used for that trigger; it applies at the next IDLE cycle.
  - Writes during COUNT or WAIT_LOW stay pending.
- State machine:
  - IDLE: on edge & global_en, go to COUNT with mstr=0, blk=0, fired=0, trig_count+1. An edge with global_en=0 is ignored.
  - COUNT: blk increments each cycle. When blk==BLK_SIZE, blk becomes 0 and mstr increments.
  - COUNT, channel i fires when active_en[i] & ~fired[i] & global_en & blk==0 & mstr==active_dly[i]. amp_trig[i] is high for exactly the next cycle, and fired[i] is set.
  - COUNT exit, trig_s==0: go to IDLE. miss[i] is set for each active_en[i] & ~fired[i]. The cycle that exits cannot fire.
  - COUNT exit, all enabled channels fired, or the mstr==2^DLY_W-1 block has ended: go to WAIT_LOW. mstr never wraps.
  - WAIT_LOW: go to IDLE when trig_s==0. A new edge needs trig_s low and then high again.
- global_en deasserted mid-COUNT suppresses further pulses; sequencing and miss logic continue.
- miss_clr clears miss. If a miss-set event occurs in the same cycle, the set wins.
- Latency: trigger_in rises before clock edge k; the delay-d pulse is high after edge k+3+d*(BLK_SIZE+1), for one cycle.
- Channels with equal delays fire in the same cycle.
- Asynchronous reset mid-sequence: pulses stop immediately and all state returns to reset values.

Test Plan:
- Post-reset channels 0/1 enabled, delays 0 and 3; rising trigger before edge k, held 100 cycles -> amp_trig[0] high after edge k+3, amp_trig[1] high after edge k+66, each 1 cycle; trig_count=1; busy low after trigger falls.
- Channel 2 delay 10 (fires at k+213); trigger falls after 150 cycles -> no pulse, miss[2]=1; miss_clr -> miss[2]=0.
- cfg_wr ch0 delay 5 while busy -> cfg_ack next cycle, cfg_pending=1; current trigger still uses delay 0; next trigger fires at k+108; cfg_pending=0 once IDLE.
- trigger_in high through reset release -> no pulse; falling then rising edge -> normal sequence.
- global_en=0 at edge -> no pulses, trig_count unchanged; global_en dropped mid-COUNT -> later channels suppressed and flagged in miss if trigger falls first.
- Delay 127, trigger held 3000 cycles -> pulse after edge k+3+127*21=k+2670; WAIT_LOW until trigger falls; no second pulse.

Source files
------------

// File: rtl/amp_trig_sched.sv
// amp_trig_sched: multi-channel amplifier trigger scheduler.
// Synchronises an external trigger, counts coarse blocks of BLK_SIZE+1 clocks
// and fires a one-cycle pulse per enabled channel at its programmed block delay.
// Channel configuration is double-buffered and only applied while idle.
module amp_trig_sched #(
  parameter int NCH      = 4,
  parameter int BLK_SIZE = 20,
  parameter int DLY_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger_in,
  input  logic             global_en,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_ch,
  input  logic             cfg_en,
  input  logic [DLY_W-1:0] cfg_delay,
  output logic             cfg_ack,
  output logic             cfg_pending,
  input  logic             miss_clr,
  output logic [NCH-1:0]   amp_trig,
  output logic             busy,
  output logic [15:0]      trig_count,
  output logic [NCH-1:0]   miss
);

  localparam int               BW        = (BLK_SIZE < 1) ? 1 : $clog2(BLK_SIZE + 1);
  localparam logic [BW-1:0]    BLK_LAST  = BW'(BLK_SIZE);
  localparam logic [DLY_W-1:0] MSTR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // Trigger synchroniser and edge detection
  logic       sync1_q;
  logic       trig_s_q;
  logic       trig_d_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       trig_edge;

  // Sequencer state
  state_t           state_q, state_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic [DLY_W-1:0] mstr_q, mstr_d;
  logic [NCH-1:0]   fired_q, fired_d;
  logic [15:0]      trig_count_q, trig_count_d;
  logic [NCH-1:0]   amp_trig_q;
  logic [NCH-1:0]   miss_q, miss_d;
  logic [NCH-1:0]   miss_set;
  logic             pending_q, pending_d;
  logic             cfg_ack_q;
  logic             apply_cfg;

  // Per-channel views of the active configuration
  logic [NCH-1:0]   act_en;
  logic [NCH-1:0]   fire;
  logic             count_live;
  logic             blk_wrap;

  // Two-flop synchroniser plus delayed copy. fill_q marks when trig_s_q holds a
  // real sample of the pin rather than its reset value, so a trigger held high
  // across reset release never arms the detector until it has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      trig_s_q <= 1'b0;
      trig_d_q <= 1'b0;
      fill_q   <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= trigger_in;
      trig_s_q <= sync1_q;
      trig_d_q <= trig_s_q;
      fill_q   <= {fill_q[0], 1'b1};
      if (fill_q[1] && !trig_s_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign trig_edge  = trig_s_q & ~trig_d_q & armed_q;
  // A cycle in COUNT where the trigger is already low is an exit cycle and may not fire.
  assign count_live = (state_q == COUNT) && trig_s_q;
  assign blk_wrap   = (blk_q == BLK_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic             sh_en_q;
      logic [DLY_W-1:0] sh_dly_q;
      logic             act_en_q;
      logic [DLY_W-1:0] act_dly_q;

      // Shadow entry takes host writes; active entry loads from shadow while idle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_en_q   <= 1'b0;
          sh_dly_q  <= '0;
          act_en_q  <= 1'b0;
          act_dly_q <= '0;
        end else begin
          if (cfg_wr && (cfg_ch == 3'(gi))) begin
            sh_en_q  <= cfg_en;
            sh_dly_q <= cfg_delay;
          end
          if (apply_cfg) begin
            act_en_q  <= sh_en_q;
            act_dly_q <= sh_dly_q;
          end
        end
      end

      assign act_en[gi] = act_en_q;
      assign fire[gi]   = count_live & act_en_q & ~fired_q[gi] & global_en &
                          (blk_q == '0) & (mstr_q == act_dly_q);
    end
  endgenerate

  // Next-state logic for the trigger sequencer and config handshake
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    mstr_d       = mstr_q;
    fired_d      = fired_q;
    trig_count_d = trig_count_q;
    miss_set     = '0;
    apply_cfg    = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig_edge && global_en) begin
          state_d      = COUNT;
          blk_d        = '0;
          mstr_d       = '0;
          fired_d      = '0;
          trig_count_d = trig_count_q + 16'd1;
        end
        // Never swap configuration on the cycle an edge is being looked at.
        if (pending_q && !trig_edge) begin
          apply_cfg = 1'b1;
        end
      end

      COUNT: begin
        if (!trig_s_q) begin
          state_d  = IDLE;
          miss_set = act_en & ~fired_q;
        end else begin
          fired_d = fired_q | fire;
          if (blk_wrap) begin
            blk_d = '0;
            if (mstr_q != MSTR_LAST) begin
              mstr_d = mstr_q + 1'b1;
            end
          end else begin
            blk_d = blk_q + 1'b1;
          end
          // Done once every enabled channel has fired, or the last block has run out.
          if (((act_en & ~fired_d) == '0) || (blk_wrap && (mstr_q == MSTR_LAST))) begin
            state_d = WAIT_LOW;
          end
        end
      end

      WAIT_LOW: begin
        if (!trig_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = cfg_wr | (pending_q & ~apply_cfg);
    // A miss reported in the same cycle as a clear must survive.
    miss_d    = (miss_q & ~{NCH{miss_clr}}) | miss_set;
  end

  // Sequencer, pulse and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      blk_q        <= '0;
      mstr_q       <= '0;
      fired_q      <= '0;
      trig_count_q <= '0;
      amp_trig_q   <= '0;
      miss_q       <= '0;
      pending_q    <= 1'b0;
      cfg_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      mstr_q       <= mstr_d;
      fired_q      <= fired_d;
      trig_count_q <= trig_count_d;
      amp_trig_q   <= fire;
      miss_q       <= miss_d;
      pending_q    <= pending_d;
      cfg_ack_q    <= cfg_wr;
    end
  end

  assign amp_trig    = amp_trig_q;
  assign busy        = (state_q != IDLE);
  assign trig_count  = trig_count_q;
  assign miss        = miss_q;
  assign cfg_ack     = cfg_ack_q;
  assign cfg_pending = pending_q;

endmodule

// File: tb/tb_amp_trig_sched.sv
// Testbench for amp_trig_sched: table of trigger episodes, a few hand-written
// corner sequences and randomized episodes checked against an arithmetic model
// of pulse timing (pulse at edge k+3+d*(BLK+1) iff the trigger is held long enough).
`timescale 1ns/1ps
module tb_amp_trig_sched;

  localparam int NCH = 4;
  localparam int BLK = 20;
  localparam int DW  = 7;
  localparam int PER = BLK + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            trigger_in = 1'b0;
  logic            global_en = 1'b0;
  logic            cfg_wr = 1'b0;
  logic [2:0]      cfg_ch = 3'd0;
  logic            cfg_en = 1'b0;
  logic [DW-1:0]   cfg_delay = '0;
  logic            miss_clr = 1'b0;
  logic            cfg_ack;
  logic            cfg_pending;
  logic [NCH-1:0]  amp_trig;
  logic            busy;
  logic [15:0]     trig_count;
  logic [NCH-1:0]  miss;

  amp_trig_sched #(.NCH(NCH), .BLK_SIZE(BLK), .DLY_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_in  (trigger_in),
    .global_en   (global_en),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_en      (cfg_en),
    .cfg_delay   (cfg_delay),
    .cfg_ack     (cfg_ack),
    .cfg_pending (cfg_pending),
    .miss_clr    (miss_clr),
    .amp_trig    (amp_trig),
    .busy        (busy),
    .trig_count  (trig_count),
    .miss        (miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: programmed configuration, expected counter and sticky misses
  logic [NCH-1:0] cur_en = '0;
  logic [DW-1:0]  cur_dly [NCH];
  logic [15:0]    cnt_exp = '0;
  logic [NCH-1:0] miss_exp = '0;

  typedef struct {
    logic [3:0] en;
    logic [6:0] d0, d1, d2, d3;
    int         hold;        // trigger high for this many clocks
    logic       gen;         // global_en at the edge
    int         gen_drop_n;  // drop global_en after this cycle (-1 never)
    int         wr_n;        // write ch0 en=1 delay=5 at this cycle (-1 never)
    logic       reprog;      // program all channels before the episode
    logic [3:0] exp_fire;    // channels expected to pulse
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic en, input logic [DW-1:0] d);
    cfg_wr    = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_en    = en;
    cfg_delay = d;
    tick();
    check($sformatf("cfg ch%0d ack", ch), 32'(cfg_ack), 32'd1);
    check($sformatf("cfg ch%0d pending", ch), 32'(cfg_pending), 32'd1);
    cfg_wr = 1'b0;
    tick();
    check($sformatf("cfg ch%0d ack_low", ch), 32'(cfg_ack), 32'd0);
    check($sformatf("cfg ch%0d pending_clr", ch), 32'(cfg_pending), 32'd0);
    if (ch < NCH) begin
      cur_en[ch]  = en;
      cur_dly[ch] = d;
    end
  endtask

  // One trigger episode: trigger rises before edge k, n counts edges after k.
  task automatic run_vec(input string tag, input vec_t v);
    int             pulse_n [NCH];
    logic [NCH-1:0] en_snap;
    logic [NCH-1:0] exp_amp;
    logic           exp_busy;
    if (v.reprog) begin
      cfg_write(0, v.en[0], v.d0);
      cfg_write(1, v.en[1], v.d1);
      cfg_write(2, v.en[2], v.d2);
      cfg_write(3, v.en[3], v.d3);
    end
    for (int i = 0; i < NCH; i++) pulse_n[i] = 3 + int'(cur_dly[i]) * PER;
    en_snap    = cur_en;
    global_en  = v.gen;
    trigger_in = 1'b1;
    for (int n = 0; n <= v.hold + 5; n++) begin
      tick();
      for (int i = 0; i < NCH; i++) exp_amp[i] = v.exp_fire[i] && (n == pulse_n[i]);
      exp_busy = v.gen && (n >= 2) && (n <= v.hold + 1);
      check($sformatf("%s amp_trig n=%0d", tag, n), 32'(amp_trig), 32'(exp_amp));
      check($sformatf("%s busy n=%0d", tag, n), 32'(busy), 32'(exp_busy));
      if (v.wr_n >= 0 && n == v.wr_n + 1) begin
        cfg_wr = 1'b0;
        check($sformatf("%s busy-write ack", tag), 32'(cfg_ack), 32'd1);
        check($sformatf("%s busy-write pending", tag), 32'(cfg_pending), 32'd1);
        cur_en[0]  = 1'b1;
        cur_dly[0] = 7'd5;
      end
      if (v.wr_n >= 0 && n == v.wr_n) begin
        cfg_wr    = 1'b1;
        cfg_ch    = 3'd0;
        cfg_en    = 1'b1;
        cfg_delay = 7'd5;
      end
      if (n == v.hold - 1) trigger_in = 1'b0;
      if (n == v.gen_drop_n) global_en = 1'b0;
    end
    if (v.gen) begin
      cnt_exp  = cnt_exp + 16'd1;
      miss_exp = miss_exp | (en_snap & ~v.exp_fire);
    end
    check($sformatf("%s trig_count", tag), 32'(trig_count), 32'(cnt_exp));
    check($sformatf("%s miss", tag), 32'(miss), 32'(miss_exp));
    check($sformatf("%s pending_end", tag), 32'(cfg_pending), 32'd0);
    global_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    logic [6:0] dl [NCH];

    for (int i = 0; i < NCH; i++) cur_dly[i] = '0;
    //          en       d0     d1     d2     d3     hold  gen   drop  wr   reprog fire
    tbl[0]  = '{4'b0011, 7'd0,  7'd3,  7'd0,  7'd0,  100,  1'b1, -1,   -1,  1'b1,  4'b0011};
    tbl[1]  = '{4'b0100, 7'd0,  7'd0,  7'd10, 7'd0,  150,  1'b1, -1,   -1,  1'b1,  4'b0000};
    tbl[2]  = '{4'b1111, 7'd2,  7'd2,  7'd5,  7'd1,  200,  1'b1, -1,   -1,  1'b1,  4'b1111};
    tbl[3]  = '{4'b0001, 7'd0,  7'd0,  7'd0,  7'd0,  30,   1'b0, -1,   -1,  1'b1,  4'b0000};
    tbl[4]  = '{4'b0001, 7'd127,7'd0,  7'd0,  7'd0,  3000, 1'b1, -1,   -1,  1'b1,  4'b0001};
    tbl[5]  = '{4'b0000, 7'd0,  7'd0,  7'd0,  7'd0,  20,   1'b1, -1,   -1,  1'b1,  4'b0000};
    tbl[6]  = '{4'b1010, 7'd0,  7'd1,  7'd0,  7'd4,  50,   1'b1, -1,   -1,  1'b1,  4'b0010};
    tbl[7]  = '{4'b0001, 7'd0,  7'd0,  7'd0,  7'd0,  100,  1'b1, -1,   10,  1'b1,  4'b0001};
    tbl[8]  = '{4'b0001, 7'd5,  7'd0,  7'd0,  7'd0,  150,  1'b1, -1,   -1,  1'b0,  4'b0001};
    tbl[9]  = '{4'b0011, 7'd0,  7'd3,  7'd0,  7'd0,  100,  1'b1, 20,   -1,  1'b1,  4'b0001};
    tbl[10] = '{4'b0001, 7'd2,  7'd0,  7'd0,  7'd0,  44,   1'b1, -1,   -1,  1'b1,  4'b0001};
    tbl[11] = '{4'b0001, 7'd2,  7'd0,  7'd0,  7'd0,  43,   1'b1, -1,   -1,  1'b1,  4'b0000};

    // Reset with the trigger already high
    trigger_in = 1'b1;
    global_en  = 1'b1;
    repeat (3) tick();
    check("reset amp_trig", 32'(amp_trig), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset trig_count", 32'(trig_count), 32'd0);
    check("reset miss", 32'(miss), 32'd0);
    check("reset cfg_ack", 32'(cfg_ack), 32'd0);
    check("reset cfg_pending", 32'(cfg_pending), 32'd0);
    rst_n = 1'b1;

    // Trigger held through reset release must not start a sequence
    for (int n = 0; n < 20; n++) begin
      tick();
      check($sformatf("held-trig amp n=%0d", n), 32'(amp_trig), 32'd0);
      check($sformatf("held-trig busy n=%0d", n), 32'(busy), 32'd0);
    end
    cfg_write(0, 1'b1, 7'd0);
    cfg_write(5, 1'b1, 7'd1);
    check("held-trig trig_count", 32'(trig_count), 32'd0);
    trigger_in = 1'b0;
    repeat (5) tick();

    // Table of episodes
    for (int t = 0; t < 12; t++) run_vec($sformatf("vec%0d", t), tbl[t]);

    // Sticky miss flags clear on miss_clr
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    miss_exp = '0;
    check("miss_clr", 32'(miss), 32'(miss_exp));

    // Randomized episodes against the timing model
    for (int r = 0; r < 8; r++) begin
      rv.en = 4'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) dl[i] = 7'($urandom_range(0, 15));
      rv.d0 = dl[0];
      rv.d1 = dl[1];
      rv.d2 = dl[2];
      rv.d3 = dl[3];
      rv.hold       = int'($urandom_range(1, 340));
      rv.gen        = 1'b1;
      rv.gen_drop_n = -1;
      rv.wr_n       = -1;
      rv.reprog     = 1'b1;
      for (int i = 0; i < NCH; i++)
        rv.exp_fire[i] = rv.en[i] && (int'(dl[i]) * PER + 2 <= rv.hold);
      run_vec($sformatf("rnd%0d", r), rv);
    end

    // Asynchronous reset in the middle of a sequence
    cfg_write(0, 1'b1, 7'd10);
    trigger_in = 1'b1;
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check("midreset amp_trig", 32'(amp_trig), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset trig_count", 32'(trig_count), 32'd0);
    check("midreset miss", 32'(miss), 32'd0);
    check("midreset cfg_pending", 32'(cfg_pending), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    trigger_in = 1'b0;
    repeat (3) tick();
    check("postreset busy", 32'(busy), 32'd0);
    check("postreset trig_count", 32'(trig_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
